// File: rtl/fare_accum.sv
// Trip fare accumulator: synchronises the km and wait-fare pulse inputs, runs the
// IDLE/RUN/HOLD trip state machine and keeps the running fare and distance in BCD.
module fare_accum #(
  parameter logic [15:0] START_FARE = 16'h0100,
  parameter logic [7:0]  BASE_KM    = 8'h03,
  parameter logic [15:0] KM_FARE    = 16'h0020,
  parameter logic [15:0] WAIT_FARE  = 16'h0010
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        trip_start,
  input  logic        trip_end,
  input  logic        clr,
  input  logic        km_pulse,
  input  logic        wait_fare_pulse,
  output logic [15:0] fare_bcd,
  output logic [7:0]  km_bcd,
  output logic        running,
  output logic        fare_upd
);

  typedef enum logic [1:0] {IDLE = 2'd0, RUN = 2'd1, HOLD = 2'd2} state_e;

  // Digit-wise BCD add; bit 16 is the decimal carry out of the top digit.
  function automatic logic [16:0] bcd_add16(input logic [15:0] a, input logic [15:0] b);
    logic [4:0]  s;
    logic [4:0]  t;
    logic        c;
    logic [15:0] r;
    c = 1'b0;
    r = 16'h0000;
    for (int i = 0; i < 4; i++) begin
      s = {1'b0, a[4*i +: 4]} + {1'b0, b[4*i +: 4]} + {4'd0, c};
      if (s > 5'd9) begin
        t = s - 5'd10;
        r[4*i +: 4] = t[3:0];
        c = 1'b1;
      end else begin
        r[4*i +: 4] = s[3:0];
        c = 1'b0;
      end
    end
    return {c, r};
  endfunction

  function automatic logic [15:0] bcd_sat_add(input logic [15:0] a, input logic [15:0] b);
    logic [16:0] sum;
    sum = bcd_add16(a, b);
    return sum[16] ? 16'h9999 : sum[15:0];
  endfunction

  state_e      state_q, state_d;
  logic [15:0] fare_q, fare_d;
  logic [7:0]  km_q, km_d;
  logic        running_q, running_d;
  logic        charge_q, charge_d;
  logic        fare_upd_q, fare_upd_d;
  logic [2:0]  km_sync_q, km_sync_d;
  logic [2:0]  wait_sync_q, wait_sync_d;
  logic        km_ev_s, wait_ev_s, km_chg_s;
  logic [16:0] km_sum_s;
  logic [15:0] fare_acc_s;

  assign km_ev_s   = km_sync_q[1] & ~km_sync_q[2];
  assign wait_ev_s = wait_sync_q[1] & ~wait_sync_q[2];
  assign km_chg_s  = km_ev_s & (km_q >= BASE_KM);

  always_comb begin
    state_d     = state_q;
    fare_d      = fare_q;
    km_d        = km_q;
    charge_d    = 1'b0;
    km_sync_d   = {km_sync_q[1:0], km_pulse};
    wait_sync_d = {wait_sync_q[1:0], wait_fare_pulse};
    km_sum_s    = bcd_add16({8'h00, km_q}, 16'h0001);
    fare_acc_s  = fare_q;
    case (state_q)
      IDLE: begin
        if (trip_start) begin
          state_d = RUN;
          fare_d  = START_FARE;
          km_d    = 8'h00;
        end else begin
          state_d = IDLE;
        end
      end
      RUN: begin
        if (trip_end) begin
          state_d = HOLD;
        end else begin
          state_d = RUN;
        end
        // Both charges may land in one cycle; they are chained so neither is lost.
        if (km_chg_s) begin
          fare_acc_s = bcd_sat_add(fare_acc_s, KM_FARE);
        end else begin
          fare_acc_s = fare_acc_s;
        end
        if (wait_ev_s) begin
          fare_acc_s = bcd_sat_add(fare_acc_s, WAIT_FARE);
        end else begin
          fare_acc_s = fare_acc_s;
        end
        fare_d = fare_acc_s;
        if (km_ev_s && (km_q != 8'h99)) begin
          km_d = km_sum_s[7:0];
        end else begin
          km_d = km_q;
        end
        charge_d = wait_ev_s | km_chg_s;
      end
      HOLD: begin
        if (trip_start) begin
          state_d = RUN;
          fare_d  = START_FARE;
          km_d    = 8'h00;
        end else if (clr) begin
          state_d = IDLE;
          fare_d  = 16'h0000;
          km_d    = 8'h00;
        end else begin
          state_d = HOLD;
        end
      end
      default: begin
        state_d = IDLE;
        fare_d  = 16'h0000;
        km_d    = 8'h00;
      end
    endcase
    running_d  = (state_d == RUN);
    fare_upd_d = charge_q;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      fare_q      <= 16'h0000;
      km_q        <= 8'h00;
      running_q   <= 1'b0;
      charge_q    <= 1'b0;
      fare_upd_q  <= 1'b0;
      km_sync_q   <= 3'b000;
      wait_sync_q <= 3'b000;
    end else begin
      state_q     <= state_d;
      fare_q      <= fare_d;
      km_q        <= km_d;
      running_q   <= running_d;
      charge_q    <= charge_d;
      fare_upd_q  <= fare_upd_d;
      km_sync_q   <= km_sync_d;
      wait_sync_q <= wait_sync_d;
    end
  end

  assign fare_bcd = fare_q;
  assign km_bcd   = km_q;
  assign running  = running_q;
  assign fare_upd = fare_upd_q;

endmodule

// File: tb/tb_fare_accum.sv
// Randomised bench for fare_accum: an integer trip model predicts fare/km; expected
// values for each charge are queued and checked by a monitor whenever fare_upd fires.
module tb_fare_accum;

  logic        clk = 1'b0;
  logic        rst, trip_start, trip_end, clr, km_pulse, wait_fare_pulse;
  logic [15:0] fare_bcd;
  logic [7:0]  km_bcd;
  logic        running, fare_upd;

  int total = 0;
  int bad   = 0;

  typedef struct {
    logic [15:0] f;
    logic [7:0]  k;
  } exp_t;
  exp_t sbq[$];

  // model: st 0=idle 1=run 2=hold; fare in tenths of a yuan, km as plain integers
  int mst, mfare, mkm;

  fare_accum dut (
    .clk(clk), .rst(rst), .trip_start(trip_start), .trip_end(trip_end), .clr(clr),
    .km_pulse(km_pulse), .wait_fare_pulse(wait_fare_pulse),
    .fare_bcd(fare_bcd), .km_bcd(km_bcd), .running(running), .fare_upd(fare_upd)
  );

  always #5 clk = ~clk;

  function automatic logic [15:0] to_bcd(input int v);
    return {4'((v / 1000) % 10), 4'((v / 100) % 10), 4'((v / 10) % 10), 4'(v % 10)};
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    exp_t e;
    if (fare_upd === 1'b1) begin
      chk("sb_nonempty", 32'(sbq.size() > 0), 32'd1);
      if (sbq.size() > 0) begin
        e = sbq.pop_front();
        chk("sb_fare", 32'(fare_bcd), 32'(e.f));
        chk("sb_km", 32'(km_bcd), 32'(e.k));
      end
    end
  end

  task automatic check_model(input string tag);
    chk({tag, "_fare"}, 32'(fare_bcd), 32'(to_bcd(mfare)));
    chk({tag, "_km"}, 32'(km_bcd), 32'(to_bcd(mkm)));
    chk({tag, "_run"}, 32'(running), 32'(mst == 1));
  endtask

  task automatic pulse(input bit k, input bit w);
    int   of, ok, add;
    bit   ch;
    exp_t e;
    of = mfare;
    ok = mkm;
    if (mst == 1) begin
      add = 0;
      if (k && mkm >= 3) add += 20;
      if (w) add += 10;
      ch = w || (k && mkm >= 3);
      mfare = (mfare + add > 9999) ? 9999 : mfare + add;
      if (k && mkm < 99) mkm++;
      if (ch) begin
        e.f = to_bcd(mfare);
        e.k = to_bcd(mkm)[7:0];
        sbq.push_back(e);
      end
    end
    @(negedge clk);
    km_pulse = k;
    wait_fare_pulse = w;
    @(negedge clk);
    @(negedge clk);
    chk("lat_pre_fare", 32'(fare_bcd), 32'(to_bcd(of)));
    chk("lat_pre_km", 32'(km_bcd), 32'(to_bcd(ok)));
    km_pulse = 1'b0;
    wait_fare_pulse = 1'b0;
    @(negedge clk);
    check_model("post");
    @(negedge clk);
    repeat ($urandom_range(0, 2)) @(negedge clk);
  endtask

  task automatic strobe(input bit ts, input bit te, input bit cl);
    @(negedge clk);
    trip_start = ts;
    trip_end = te;
    clr = cl;
    case (mst)
      0: if (ts) begin mst = 1; mfare = 100; mkm = 0; end
      1: if (te) mst = 2;
      2: if (ts) begin mst = 1; mfare = 100; mkm = 0; end
         else if (cl) begin mst = 0; mfare = 0; mkm = 0; end
      default: mst = 0;
    endcase
    @(negedge clk);
    trip_start = 1'b0;
    trip_end = 1'b0;
    clr = 1'b0;
    check_model("strobe");
  endtask

  initial begin
    int r, v;
    rst = 1'b1;
    trip_start = 1'b0; trip_end = 1'b0; clr = 1'b0;
    km_pulse = 1'b0; wait_fare_pulse = 1'b0;
    mst = 0; mfare = 0; mkm = 0;
    repeat (5) @(negedge clk);
    rst = 1'b0;
    chk("rst_fare", 32'(fare_bcd), 32'h0);
    chk("rst_km", 32'(km_bcd), 32'h0);
    chk("rst_run", 32'(running), 32'h0);
    chk("rst_upd", 32'(fare_upd), 32'h0);

    pulse(1'b1, 1'b1);
    strobe(1'b1, 1'b0, 1'b0);
    chk("start_fare", 32'(fare_bcd), 32'h0100);
    repeat (3) pulse(1'b1, 1'b0);
    chk("base_fare", 32'(fare_bcd), 32'h0100);
    pulse(1'b1, 1'b0);
    chk("km4_fare", 32'(fare_bcd), 32'h0120);
    pulse(1'b1, 1'b0);
    repeat (4) pulse(1'b0, 1'b1);
    chk("pre_both", 32'(fare_bcd), 32'h0180);
    pulse(1'b1, 1'b1);
    chk("both_fare", 32'(fare_bcd), 32'h0210);
    chk("both_km", 32'(km_bcd), 32'h06);
    repeat (5) pulse(1'b0, 1'b1);
    strobe(1'b0, 1'b1, 1'b0);
    pulse(1'b0, 1'b1);
    pulse(1'b1, 1'b0);
    chk("hold_fare", 32'(fare_bcd), 32'h0260);
    strobe(1'b1, 1'b0, 1'b1);
    chk("hold_start_clr", 32'(fare_bcd), 32'h0100);
    strobe(1'b1, 1'b1, 1'b0);
    chk("run_start_end", 32'(running), 32'h0);
    strobe(1'b0, 1'b0, 1'b1);
    chk("clr_fare", 32'(fare_bcd), 32'h0000);

    strobe(1'b1, 1'b0, 1'b0);
    for (int i = 0; i < 250; i++) begin
      r = $urandom_range(0, 9);
      if (r <= 2) pulse(1'b1, 1'b0);
      else if (r <= 5) pulse(1'b0, 1'b1);
      else if (r == 6) pulse(1'b1, 1'b1);
      else begin
        v = $urandom_range(1, 7);
        strobe(v[0], v[1], v[2]);
      end
    end

    strobe(1'b0, 1'b1, 1'b0);
    strobe(1'b1, 1'b0, 1'b0);
    for (int i = 0; i < 400; i++) pulse(1'b1, 1'b1);
    chk("sat_fare", 32'(fare_bcd), 32'h9999);
    chk("sat_km", 32'(km_bcd), 32'h99);

    @(negedge clk);
    rst = 1'b1;
    mst = 0; mfare = 0; mkm = 0;
    @(negedge clk);
    chk("midrst_fare", 32'(fare_bcd), 32'h0);
    chk("midrst_km", 32'(km_bcd), 32'h0);
    chk("midrst_run", 32'(running), 32'h0);
    chk("midrst_upd", 32'(fare_upd), 32'h0);
    rst = 1'b0;
    strobe(1'b1, 1'b0, 1'b0);
    pulse(1'b0, 1'b1);

    repeat (6) @(negedge clk);
    chk("sb_drained", 32'(sbq.size()), 32'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
